debug_io_ctrl: RTL and testbench
================================

Name: debug_io_ctrl

Overview:
- Memory-mapped debug I/O peripheral; successor to the hard-wired buttons/RGB/LED-bits debug hookup.
- Generalised in button count and LED width.
- Adds per-button synchronisation, debouncing, sticky press events and a register interface so the RISC-V core can drive LEDs and poll buttons.
- Sits between the core's peripheral bus decode and the board pins.

Parameters:
- NUM_BUTTONS, 2, number of button inputs (1..16).
- LED_WIDTH, 8, width of the general-purpose LED output bus (1..32).
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a new button level (>=2).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- reg_addr  in  2  word index of register.
- reg_wr  in  1  write strobe, single cycle.
- reg_rd  in  1  read strobe, single cycle.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data.
- reg_rvalid  out  1  read data valid.
- btn_raw  in  NUM_BUTTONS  asynchronous button pins, active-high.
- led_bits  out  LED_WIDTH  LED outputs.
- red, green, blue  out  1 each  RGB LED outputs.

Behaviour:
- Reset (async assert, sync release): led_bits=0, red/green/blue=0, reg_rdata=0, reg_rvalid=0, synchronisers=0, debounced state=0, debounce counters=0, events=0.
- Register map:
  - 0 LED: R/W; bits [LED_WIDTH-1:0]; upper bits read 0.
  - 1 RGB: R/W; layout per Optional Feature.
  - 2 BTN_STATE: RO; debounced levels in [NUM_BUTTONS-1:0].
  - 3 BTN_EVENT: sticky press flags; write-1-to-clear.
- Writes to RO registers are ignored.
- Write: the register updates on the clock edge where reg_wr=1; outputs reflect the new value from the next cycle.
- Read: reg_rd=1 in cycle N -> reg_rvalid=1 and reg_rdata valid in cycle N+1. Otherwise reg_rvalid=0 and reg_rdata holds its last value.
- Simultaneous reg_rd and reg_wr to the same address: the read returns the pre-write value.
- Sync: each btn_raw bit passes through a 2-FF synchroniser.
- Debounce, per button: a counter increments while the synchronised value differs from the debounced state, and clears to 0 whenever they match.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced state flips and the counter clears.
  - Pin-to-BTN_STATE latency = 2 + DEBOUNCE_CYCLES cycles.
- Events: a debounced 0->1 transition sets the BTN_EVENT bit.
  - Release does not set it.
  - The bit stays set until software writes 1 to it.
- Simultaneous W1C and a new press on the same bit: set wins (bit stays 1).
- A glitch shorter than DEBOUNCE_CYCLES samples resets the counter: no state change, no event.
- Reset mid-debounce: counter and state clear; a held button is re-accepted after the full latency once reset releases.

Optional Feature:
- Macro: DEBUG_IO_PWM_EN.
- Enabled:
  - RGB register layout: [7:0] red duty, [15:8] green duty, [23:16] blue duty; [31:24] reads 0.
  - A free-running 8-bit counter (reset 0, wraps 255->0) drives each output; an output is 1 when counter < duty.
  - Duty 0 = always off; duty 255 = on 255 of 256 cycles.
  - A new duty value takes effect at the next counter wrap.
- Disabled:
  - RGB register [0]=red, [1]=green, [2]=blue; other bits read 0.
  - Outputs are driven directly from the register with no counter.

Test Plan:
- Reset: assert reset mid-run with the LED register at 0xA5. Required: led_bits=0, RGB=0, reg_rvalid=0 immediately, without waiting for a clock edge.
- LED write/read: write 0xDEADBEEF to addr 0 (LED_WIDTH=8). Required: led_bits=0xEF next cycle; reading addr 0 gives reg_rvalid=1 with 0x000000EF one cycle later.
- Debounce: hold btn_raw[0]=1 steadily (DEBOUNCE_CYCLES=16). Required: BTN_STATE bit0=1 exactly 18 cycles later and BTN_EVENT=0x1. Then apply a 5-cycle pulse on btn_raw[1]. Required: no state change and no event.
- W1C race: issue a W1C of 0x2 on the same cycle button 1's debounced press occurs. Required: BTN_EVENT bit1 stays 1. A W1C of 0x3 one cycle later gives BTN_EVENT=0.
- PWM (with DEBUG_IO_PWM_EN): write 0x00FF4000. Required: after the next wrap, red=0 always, green high for 64 of 256 cycles, blue high for 255 of 256 cycles.
- No PWM (without DEBUG_IO_PWM_EN): write 0x5. Required: red=1, green=0, blue=1 next cycle; readback gives 0x00000005.

Source files
------------

// File: rtl/debug_io_ctrl.sv
// Debug I/O peripheral: LEDs, RGB and debounced buttons behind a small register map.
// Define DEBUG_IO_PWM_EN to drive the RGB outputs from 8-bit PWM duty registers.
module debug_io_ctrl #(
    parameter int NUM_BUTTONS     = 2,
    parameter int LED_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [1:0]             reg_addr,
    input  logic                   reg_wr,
    input  logic                   reg_rd,
    input  logic [31:0]            reg_wdata,
    output logic [31:0]            reg_rdata,
    output logic                   reg_rvalid,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [LED_WIDTH-1:0]   led_bits,
    output logic                   red,
    output logic                   green,
    output logic                   blue
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic sel_led, sel_rgb, sel_st, sel_evt;
    logic [NUM_BUTTONS-1:0] sync1, sync2, state, state_n, evt, rise, clr;
    logic [NUM_BUTTONS-1:0][CW-1:0] cnt, cnt_n;
    logic [LED_WIDTH-1:0] led_q;
    logic [31:0] rgb_rd, rd_mux;
    logic unused_ok;

    assign sel_led = (reg_addr == 2'd0);
    assign sel_rgb = (reg_addr == 2'd1);
    assign sel_st  = (reg_addr == 2'd2);
    assign sel_evt = (reg_addr == 2'd3);
    assign unused_ok = ^reg_wdata;
    assign led_bits = led_q;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rise    = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (sync2[i] == state[i]) begin
                cnt_n[i] = '0;
            end else if (cnt[i] == LAST) begin
                state_n[i] = ~state[i];
                cnt_n[i]   = '0;
                rise[i]    = ~state[i];
            end else begin
                cnt_n[i] = cnt[i] + CW'(1);
            end
        end
    end

    // Set beats clear when a press lands on the same edge as a W1C.
    assign clr = (reg_wr && sel_evt) ? reg_wdata[NUM_BUTTONS-1:0] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            state <= '0;
            cnt   <= '0;
            evt   <= '0;
            led_q <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            state <= state_n;
            cnt   <= cnt_n;
            evt   <= (evt & ~clr) | rise;
            if (reg_wr && sel_led) led_q <= reg_wdata[LED_WIDTH-1:0];
        end
    end

`ifdef DEBUG_IO_PWM_EN
    logic [23:0] rgb_q, duty;
    logic [7:0]  pwm_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rgb_q   <= '0;
            duty    <= '0;
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (pwm_cnt == 8'hFF) duty <= rgb_q;
            if (reg_wr && sel_rgb) rgb_q <= reg_wdata[23:0];
        end
    end

    assign red    = pwm_cnt < duty[7:0];
    assign green  = pwm_cnt < duty[15:8];
    assign blue   = pwm_cnt < duty[23:16];
    assign rgb_rd = {8'h00, rgb_q};
`else
    logic [2:0] rgb_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rgb_q <= '0;
        end else if (reg_wr && sel_rgb) begin
            rgb_q <= reg_wdata[2:0];
        end
    end

    assign red    = rgb_q[0];
    assign green  = rgb_q[1];
    assign blue   = rgb_q[2];
    assign rgb_rd = {29'd0, rgb_q};
`endif

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            sel_led: rd_mux[LED_WIDTH-1:0]   = led_q;
            sel_rgb: rd_mux                  = rgb_rd;
            sel_st:  rd_mux[NUM_BUTTONS-1:0] = state;
            sel_evt: rd_mux[NUM_BUTTONS-1:0] = evt;
            default: rd_mux                  = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
        end else begin
            reg_rvalid <= reg_rd;
            if (reg_rd) reg_rdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_debug_io_ctrl.sv
// Scoreboard bench for debug_io_ctrl: a cycle-level reference model pushes read
// expectations; a negedge monitor pops them and checks the output pins.
module tb_debug_io_ctrl;
    localparam int NB = 2;
    localparam int LW = 8;
    localparam int D  = 16;

    logic          clock, reset;
    logic [1:0]    reg_addr;
    logic          reg_wr, reg_rd;
    logic [31:0]   reg_wdata, reg_rdata;
    logic          reg_rvalid;
    logic [NB-1:0] btn_raw;
    logic [LW-1:0] led_bits;
    logic          red, green, blue;

    debug_io_ctrl #(.NUM_BUTTONS(NB), .LED_WIDTH(LW), .DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .reset(reset), .reg_addr(reg_addr), .reg_wr(reg_wr),
        .reg_rd(reg_rd), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
        .reg_rvalid(reg_rvalid), .btn_raw(btn_raw), .led_bits(led_bits),
        .red(red), .green(green), .blue(blue)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model state
    logic [31:0]   exp_q[$];
    logic [NB-1:0] hist[$];
    logic [LW-1:0] m_led;
    logic [NB-1:0] m_state, m_evt;
`ifdef DEBUG_IO_PWM_EN
    logic [23:0]   m_rgb, m_duty;
    int            m_pc;
`else
    logic [2:0]    m_rgb;
`endif

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[LW-1:0] = m_led;
            2'd1: r = 32'(m_rgb);
            2'd2: r[NB-1:0] = m_state;
            default: r[NB-1:0] = m_evt;
        endcase
        return r;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            exp_q.delete();
            hist.delete();
            for (int i = 0; i < D + 2; i++) hist.push_back('0);
            m_led = '0; m_state = '0; m_evt = '0; m_rgb = '0;
`ifdef DEBUG_IO_PWM_EN
            m_duty = '0; m_pc = 0;
`endif
        end else begin
            logic [NB-1:0] rs;
            int n;
            if (reg_rd) exp_q.push_back(model_read(reg_addr));
            hist.push_back(btn_raw);
            if (hist.size() > D + 2) void'(hist.pop_front());
            n = hist.size();
            rs = '0;
            // A level is accepted once the pin (seen 2 cycles late) held it for D samples.
            for (int b = 0; b < NB; b++) begin
                bit all_v;
                all_v = 1'b1;
                for (int j = 0; j < D; j++)
                    if (hist[n-3-j][b] == m_state[b]) all_v = 1'b0;
                if (all_v) begin
                    m_state[b] = ~m_state[b];
                    rs[b] = m_state[b];
                end
            end
            if (reg_wr && reg_addr == 2'd3) m_evt = m_evt & ~reg_wdata[NB-1:0];
            m_evt = m_evt | rs;
`ifdef DEBUG_IO_PWM_EN
            if (m_pc == 255) m_duty = m_rgb;
            m_pc = (m_pc + 1) % 256;
            if (reg_wr && reg_addr == 2'd1) m_rgb = reg_wdata[23:0];
`else
            if (reg_wr && reg_addr == 2'd1) m_rgb = reg_wdata[2:0];
`endif
            if (reg_wr && reg_addr == 2'd0) m_led = reg_wdata[LW-1:0];
        end
    end

    // Monitor
    always @(negedge clock) begin
        if (!reset) begin
            chk("rvalid", 32'(reg_rvalid), 32'(exp_q.size() != 0));
            if (reg_rvalid && exp_q.size() != 0) chk("rdata", reg_rdata, exp_q.pop_front());
            chk("led_pins", 32'(led_bits), 32'(m_led));
`ifdef DEBUG_IO_PWM_EN
            chk("rgb_pins", {29'd0, blue, green, red},
                {29'd0, m_pc < m_duty[23:16], m_pc < m_duty[15:8], m_pc < m_duty[7:0]});
`else
            chk("rgb_pins", {29'd0, blue, green, red}, 32'(m_rgb));
`endif
        end
    end

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clock);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        @(negedge clock);
        reg_wr = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        @(negedge clock);
        reg_rd = 1'b1; reg_addr = a;
        @(negedge clock);
        reg_rd = 1'b0;
    endtask

    task automatic rd_burst(input logic [1:0] a, input int cycles);
        @(negedge clock);
        reg_rd = 1'b1; reg_addr = a;
        repeat (cycles) @(negedge clock);
        reg_rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; reg_addr = '0; reg_wr = 1'b0; reg_rd = 1'b0;
        reg_wdata = '0; btn_raw = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset_led", 32'(led_bits), 32'h0);
        chk("reset_rdata", reg_rdata, 32'h0);

        // LED write / readback
        wr(2'd0, 32'hDEADBEEF);
        chk("led_ef", 32'(led_bits), 32'hEF);
        rd(2'd0);

`ifndef DEBUG_IO_PWM_EN
        wr(2'd1, 32'h5);
        chk("rgb_101", {29'd0, blue, green, red}, 32'h5);
        rd(2'd1);
`endif

        // Steady press on button 0, polled every cycle through the latency
        @(negedge clock);
        btn_raw[0] = 1'b1;
        rd_burst(2'd2, 22);
        rd(2'd3);

        // 5-cycle glitch on button 1
        @(negedge clock);
        btn_raw[1] = 1'b1;
        repeat (5) @(negedge clock);
        btn_raw[1] = 1'b0;
        rd_burst(2'd2, 24);
        rd(2'd3);

        // W1C of bit 1 on the edge where button 1 is accepted
        @(negedge clock);
        btn_raw[1] = 1'b1;
        repeat (17) @(negedge clock);
        reg_wr = 1'b1; reg_addr = 2'd3; reg_wdata = 32'h2;
        @(negedge clock);
        reg_wdata = 32'h3;
        @(negedge clock);
        reg_wr = 1'b0;
        rd(2'd3);

        // Asynchronous reset mid-run
        wr(2'd0, 32'hA5);
        chk("led_a5", 32'(led_bits), 32'hA5);
        rd(2'd0);
        @(negedge clock);
        reg_rd = 1'b1; reg_addr = 2'd0;
        @(posedge clock);
        reg_rd = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_led", 32'(led_bits), 32'h0);
        chk("arst_rgb", {29'd0, blue, green, red}, 32'h0);
        chk("arst_rvalid", 32'(reg_rvalid), 32'h0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        rd_burst(2'd2, 22);
        rd(2'd3);

`ifdef DEBUG_IO_PWM_EN
        begin
            int cr, cg, cb;
            wr(2'd1, 32'h00FF4000);
            rd(2'd1);
            repeat (520) @(negedge clock);
            cr = 0; cg = 0; cb = 0;
            for (int i = 0; i < 256; i++) begin
                @(negedge clock);
                cr += int'(red); cg += int'(green); cb += int'(blue);
            end
            chk("pwm_red", 32'(cr), 32'd0);
            chk("pwm_green", 32'(cg), 32'd64);
            chk("pwm_blue", 32'(cb), 32'd255);
        end
`endif

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clock);
            reg_wr    = ($urandom_range(3, 0) == 0);
            reg_rd    = ($urandom_range(2, 0) == 0);
            reg_addr  = 2'($urandom_range(3, 0));
            reg_wdata = $urandom;
            for (int b = 0; b < NB; b++)
                if ($urandom_range(23, 0) == 0) btn_raw[b] = ~btn_raw[b];
        end
        @(negedge clock);
        reg_wr = 1'b0; reg_rd = 1'b0;
        rd(2'd2);
        rd(2'd3);
        repeat (3) @(negedge clock);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
